// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, writeback FSM states, flag layout.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_NOR  = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_LUI  = 5'b01100;
  localparam logic [4:0] ALU_DIV  = 5'b01101;
  localparam logic [4:0] ALU_REM  = 5'b01110;
  localparam logic [4:0] ALU_RSVD = 5'b01111;
  localparam logic [4:0] ALU_FADD = 5'b10000;
  localparam logic [4:0] ALU_FSUB = 5'b10001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic v;
    logic c;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: holds one result, writes it to the register
// file (two beats for a multiply), keeps the V/C/Z/N flags and a retire count.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*XLEN-1:0]   in_result,
  input  logic [4:0]          in_alu_control,
  input  logic [RADDR_W-1:0]  in_rd,
  input  logic                in_v,
  input  logic                in_c,
  output logic                rf_we,
  output logic [RADDR_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  input  logic                rf_ready,
  output logic [3:0]          flags,
  output logic                rd_err,
  output logic [CNT_W-1:0]    wb_count
);

  localparam logic [RADDR_W-1:0] RD_LAST = '1;

  wb_state_t           r_state;
  wb_state_t           w_next;
  logic [2*XLEN-1:0]   r_result;
  logic [4:0]          r_op;
  logic [RADDR_W-1:0]  r_rd;
  logic                r_v;
  logic                r_c;
  flags_t              r_flags;
  logic                r_rd_err;
  logic [CNT_W-1:0]    r_count;

  logic                w_two_beat;
  logic                w_final;
  logic                w_beat_done;
  logic                w_accept;
  logic                w_retire;

  // A multiply needs a hi beat unless rd+1 would fall off the register file.
  assign w_two_beat = (r_op == ALU_MUL) && (r_rd != RD_LAST);

  // Present the current beat, derive handshakes and choose the next state.
  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    w_final     = 1'b0;
    w_beat_done = 1'b0;
    case (r_state)
      WR_LO: begin
        rf_waddr = r_rd;
        rf_wdata = r_result[XLEN-1:0];
        w_final  = !w_two_beat;
      end
      WR_HI: begin
        rf_waddr = r_rd + RADDR_W'(1);
        rf_wdata = r_result[2*XLEN-1:XLEN];
        w_final  = 1'b1;
      end
      default: ;
    endcase
    // Register 0 is never written; such a beat finishes on its own.
    if (r_state != IDLE) begin
      rf_we       = (rf_waddr != '0);
      w_beat_done = rf_we ? rf_ready : 1'b1;
    end
    in_ready = (r_state == IDLE) || (rf_ready && w_final);
    w_accept = in_valid && in_ready;
    w_retire = w_beat_done && w_final;
    w_next   = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WR_LO;
      WR_LO:   if (w_beat_done) w_next = w_two_beat ? WR_HI : (w_accept ? WR_LO : IDLE);
      WR_HI:   if (w_beat_done) w_next = w_accept ? WR_LO : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Control state: FSM, flags, sticky error and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_flags  <= '0;
      r_rd_err <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
        if (r_op == ALU_ADD || r_op == ALU_SUB)
          r_flags <= '{v: r_v, c: r_c, z: (r_result[XLEN-1:0] == '0), n: r_result[XLEN-1]};
        if (r_op == ALU_MUL && !w_two_beat)
          r_rd_err <= 1'b1;
      end
    end
  end

  // Holding register: captures the ALU result on every accepted transfer.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_result <= in_result;
      r_op     <= in_alu_control;
      r_rd     <= in_rd;
      r_v      <= in_v;
      r_c      <= in_c;
    end
  end

  assign flags    = r_flags;
  assign rd_err   = r_rd_err;
  assign wb_count = r_count;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed vectors, a queue-of-beats reference model
// checked every cycle, and literal expectations at key points.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_alu_control;
  logic [4:0]  in_rd;
  logic        in_v;
  logic        in_c;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [3:0]  flags;
  logic        rd_err;
  logic [31:0] wb_count;

  int n_checks = 0;
  int n_errors = 0;
  bit armed = 0;

  alu_writeback #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_alu_control(in_alu_control), .in_rd(in_rd), .in_v(in_v), .in_c(in_c),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags(flags), .rd_err(rd_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted op becomes one or two pending write beats.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic [4:0]  op;
    logic        v;
    logic        c;
    logic        err;
  } beat_t;

  beat_t       q[$];
  logic [3:0]  m_flags;
  logic        m_err;
  logic [31:0] m_cnt;

  function automatic logic m_ready();
    return (q.size() == 0) || (rf_ready && q[0].last);
  endfunction

  function automatic logic m_we();
    return (q.size() != 0) && (q[0].addr != 5'd0);
  endfunction

  function automatic logic [4:0] m_waddr();
    return (q.size() != 0) ? q[0].addr : 5'd0;
  endfunction

  function automatic logic [31:0] m_wdata();
    return (q.size() != 0) ? q[0].data : 32'd0;
  endfunction

  always @(posedge clk) begin
    logic  acc;
    beat_t b;
    if (rst) begin
      q.delete();
      m_flags = 4'd0;
      m_err   = 1'b0;
      m_cnt   = 32'd0;
    end else begin
      acc = in_valid && m_ready();
      if (q.size() != 0 && (q[0].addr == 5'd0 || rf_ready)) begin
        b = q.pop_front();
        if (b.last) begin
          m_cnt = m_cnt + 32'd1;
          if (b.op == 5'b00000 || b.op == 5'b00001)
            m_flags = {b.v, b.c, (b.data == 32'd0), b.data[31]};
          if (b.err) m_err = 1'b1;
        end
      end
      if (acc) begin
        if (in_alu_control == 5'b00010 && in_rd != 5'd31) begin
          q.push_back('{addr: in_rd, data: in_result[31:0], last: 1'b0,
                        op: in_alu_control, v: in_v, c: in_c, err: 1'b0});
          q.push_back('{addr: in_rd + 5'd1, data: in_result[63:32], last: 1'b1,
                        op: in_alu_control, v: in_v, c: in_c, err: 1'b0});
        end else begin
          q.push_back('{addr: in_rd, data: in_result[31:0], last: 1'b1,
                        op: in_alu_control, v: in_v, c: in_c,
                        err: (in_alu_control == 5'b00010)});
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every cycle after reset, the DUT must match the model.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 64'(in_ready), 64'(m_ready()));
      check("rf_we",    64'(rf_we),    64'(m_we()));
      check("rf_waddr", 64'(rf_waddr), 64'(m_waddr()));
      check("rf_wdata", 64'(rf_wdata), 64'(m_wdata()));
      check("flags",    64'(flags),    64'(m_flags));
      check("rd_err",   64'(rd_err),   64'(m_err));
      check("wb_count", 64'(wb_count), 64'(m_cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one result; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [4:0] op, input logic [63:0] res, input logic [4:0] rd,
                      input logic v, input logic c);
    int n;
    n = 0;
    in_valid       = 1'b1;
    in_alu_control = op;
    in_result      = res;
    in_rd          = rd;
    in_v           = v;
    in_c           = c;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout at %0t: in_ready=%0b after %0d cycles, required 1", $time, in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_result = '0;
    in_alu_control = '0;
    in_rd = '0;
    in_v = 1'b0;
    in_c = 1'b0;
    rf_ready = 1'b1;
    step(2);
    rst = 1'b0;
    armed = 1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    step(1);

    // ADD: carry out, zero low word
    send(5'b00000, 64'h1_0000_0000, 5'd3, 1'b0, 1'b1);
    @(negedge clk);
    check("add_we", 64'(rf_we), 64'd1);
    check("add_waddr", 64'(rf_waddr), 64'd3);
    check("add_wdata", 64'(rf_wdata), 64'd0);
    step(2);
    check("add_flags", 64'(flags), 64'b0110);
    check("add_count", 64'(wb_count), 64'd1);

    // MUL: lo beat then hi beat, flags untouched
    send(5'b00010, 64'hDEAD_BEEF_1234_5678, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    check("mul_lo_waddr", 64'(rf_waddr), 64'd7);
    check("mul_lo_wdata", 64'(rf_wdata), 64'h1234_5678);
    check("mul_lo_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("mul_hi_waddr", 64'(rf_waddr), 64'd8);
    check("mul_hi_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    step(2);
    check("mul_flags", 64'(flags), 64'b0110);
    check("mul_count", 64'(wb_count), 64'd2);

    // Back-to-back XORs
    send(5'b00101, 64'h0000_0000_0000_00A1, 5'd1, 1'b0, 1'b0);
    send(5'b00101, 64'h0000_0000_0000_00A2, 5'd2, 1'b0, 1'b0);
    send(5'b00101, 64'h0000_0000_0000_00A3, 5'd3, 1'b0, 1'b0);
    step(2);
    check("xor_count", 64'(wb_count), 64'd5);

    // SUB stalled by the register file for 4 cycles
    rf_ready = 1'b0;
    send(5'b00001, 64'h0000_0000_8000_0000, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_we", 64'(rf_we), 64'd1);
      check("stall_waddr", 64'(rf_waddr), 64'd5);
      check("stall_wdata", 64'(rf_wdata), 64'h8000_0000);
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rf_ready = 1'b1;
    step(2);
    check("sub_flags", 64'(flags), 64'b1001);
    check("sub_count", 64'(wb_count), 64'd6);

    // MUL to r31: single write, sticky error
    send(5'b00010, 64'hAAAA_BBBB_0000_0001, 5'd31, 1'b0, 1'b0);
    @(negedge clk);
    check("mul31_waddr", 64'(rf_waddr), 64'd31);
    check("mul31_wdata", 64'(rf_wdata), 64'd1);
    check("mul31_ready", 64'(in_ready), 64'd1);
    step(1);
    check("mul31_err", 64'(rd_err), 64'd1);
    check("mul31_count", 64'(wb_count), 64'd7);

    // ADD to r0: no write strobe, still retires
    send(5'b00000, 64'h0000_0000_0000_0005, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("r0_we", 64'(rf_we), 64'd0);
    step(1);
    check("r0_count", 64'(wb_count), 64'd8);
    check("r0_flags", 64'(flags), 64'b0000);

    // Reserved opcode: ordinary single write
    send(5'b01111, 64'h0, 5'd9, 1'b1, 1'b1);
    step(2);
    check("rsvd_count", 64'(wb_count), 64'd9);
    check("rsvd_err", 64'(rd_err), 64'd1);

    // Reset while the hi beat is pending
    send(5'b00010, 64'h1111_2222_3333_4444, 5'd10, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rf_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rf_ready = 1'b1;
    @(negedge clk);
    check("rstwr_we", 64'(rf_we), 64'd0);
    check("rstwr_flags", 64'(flags), 64'd0);
    check("rstwr_count", 64'(wb_count), 64'd0);
    check("rstwr_ready", 64'(in_ready), 64'd1);
    check("rstwr_err", 64'(rd_err), 64'd0);
    step(3);

    armed = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
